// File: rtl/pam4_ber_pkg.sv
// Shared encodings for the PAM4 PRBS7 bit-error-rate checker: FSM states,
// Gray level codes, PRBS7 tap positions and counter saturation values.
package pam4_ber_pkg;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_QUAL   = 2'd1,
    ST_LOCKED = 2'd2
  } ber_state_e;

  // Gray {MSB,LSB} per PAM4 level
  localparam logic [1:0] GRAY_P3 = 2'b10;
  localparam logic [1:0] GRAY_P1 = 2'b11;
  localparam logic [1:0] GRAY_M1 = 2'b01;
  localparam logic [1:0] GRAY_M3 = 2'b00;

  // History index 0 is the newest bit, so b[n-7] sits at 6 and b[n-6] at 5
  localparam int PRBS7_LEN   = 7;
  localparam int PRBS7_TAP_A = 6;
  localparam int PRBS7_TAP_B = 5;

  localparam int SEED_SYMS = 4;

  localparam int                NB_LOSS  = 8;
  localparam logic [NB_LOSS-1:0] LOSS_SAT = '1;

endpackage

// File: rtl/prbs7_predictor.sv
// PRBS7 history that either absorbs received bits (seed) or self-advances with
// its own predictions (predict), two bits (MSB first) per step.
module prbs7_predictor
  import pam4_ber_pkg::*;
(
  input  logic       gclk,
  input  logic       grst_n,
  input  logic       step_i,
  input  logic       seed_i,
  input  logic [1:0] rx_bits_i,
  output logic [1:0] pred_bits_o
);

  logic [PRBS7_LEN-1:0] hist_q, hist_d;

  // The LSB prediction uses the history as it will look after the MSB shifts in
  assign pred_bits_o[1] = hist_q[PRBS7_TAP_A]   ^ hist_q[PRBS7_TAP_B];
  assign pred_bits_o[0] = hist_q[PRBS7_TAP_A-1] ^ hist_q[PRBS7_TAP_B-1];

  always_comb begin
    hist_d = hist_q;
    if (step_i) begin
      if (seed_i) hist_d = {hist_q[PRBS7_LEN-3:0], rx_bits_i};
      else        hist_d = {hist_q[PRBS7_LEN-3:0], pred_bits_o};
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) hist_q <= '0;
    else         hist_q <= hist_d;
  end

endmodule

// File: rtl/pam4_ber_checker.sv
// PAM4 slicer plus PRBS7 lock/monitor FSM and saturating BER statistics.
// Stage 1 registers the decision; stage 2 compares and updates state/counters.
module pam4_ber_checker
  import pam4_ber_pkg::*;
#(
  parameter int NB_IN        = 18,
  parameter int NBF_IN       = 17,
  parameter int TH           = 65536,
  parameter int LOCK_WIN     = 64,
  parameter int LOCK_ERR_MAX = 2,
  parameter int LOSS_ERR_MAX = 16,
  parameter int NB_CNT       = 32
)(
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic signed [NB_IN-1:0]  i_sample,
  input  logic                     i_clear,
  output logic                     o_locked,
  output logic [1:0]               o_state,
  output logic [NB_CNT-1:0]        o_err_cnt,
  output logic [NB_CNT-1:0]        o_bit_cnt,
  output logic [NB_LOSS-1:0]       o_loss_cnt
);

  // Compare width leaves room for +/-1.0 thresholds in the sample's Q format
  localparam int NB_CMP = ((NB_IN > NBF_IN + 2) ? NB_IN : NBF_IN + 2) + 1;
  localparam int NB_WS  = $clog2(LOCK_WIN + 1);
  localparam int NB_WE  = $clog2(2 * LOCK_WIN + 1);

  localparam logic signed [NB_CMP-1:0] TH_POS = NB_CMP'(TH);
  localparam logic signed [NB_CMP-1:0] TH_NEG = -TH_POS;

  // ---------------- stage 1: slice and register decision ----------------
  logic signed [NB_CMP-1:0] s_ext;
  logic [1:0]               dec_d, dec_q;
  logic                     vld_q;

  assign s_ext = NB_CMP'(i_sample);

  always_comb begin
    dec_d = GRAY_M3;
    if (s_ext >= TH_POS)       dec_d = GRAY_P3;
    else if (!s_ext[NB_CMP-1]) dec_d = GRAY_P1;
    else if (s_ext >= TH_NEG)  dec_d = GRAY_M1;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      dec_q <= GRAY_M3;
      vld_q <= 1'b0;
    end else if (i_en) begin
      vld_q <= i_valid;
      if (i_valid) dec_q <= dec_d;
    end
  end

  // ---------------- stage 2: compare, FSM, statistics ----------------
  ber_state_e        state_q, state_d;
  logic [NB_WS-1:0]  win_sym_q, win_sym_d, win_sym_inc;
  logic [NB_WE-1:0]  win_err_q, win_err_d, win_err_acc;
  logic [1:0]        pred_bits, err_b, sym_err;
  logic              step, cnt_en, loss_evt;

  assign step = i_en & vld_q;

  prbs7_predictor u_pred (
    .gclk       (i_clock),
    .grst_n     (i_reset),
    .step_i     (step),
    .seed_i     (state_q == ST_SEED),
    .rx_bits_i  (dec_q),
    .pred_bits_o(pred_bits)
  );

  assign err_b       = pred_bits ^ dec_q;
  assign sym_err     = 2'(err_b[1]) + 2'(err_b[0]);
  assign win_sym_inc = win_sym_q + NB_WS'(1);
  assign win_err_acc = win_err_q + NB_WE'(sym_err);

  // Any state change or window wrap restarts both window counters at zero
  always_comb begin
    state_d   = state_q;
    win_sym_d = win_sym_q;
    win_err_d = win_err_q;
    cnt_en    = 1'b0;
    loss_evt  = 1'b0;
    if (step) begin
      win_sym_d = win_sym_inc;
      win_err_d = win_err_acc;
      case (state_q)
        ST_SEED: begin
          win_err_d = '0;
          if (win_sym_inc == NB_WS'(SEED_SYMS)) begin
            state_d   = ST_QUAL;
            win_sym_d = '0;
          end
        end
        ST_QUAL: begin
          if (win_sym_inc == NB_WS'(LOCK_WIN)) begin
            state_d   = (win_err_acc <= NB_WE'(LOCK_ERR_MAX)) ? ST_LOCKED : ST_SEED;
            win_sym_d = '0;
            win_err_d = '0;
          end
        end
        ST_LOCKED: begin
          cnt_en = 1'b1;
          if (win_err_acc >= NB_WE'(LOSS_ERR_MAX)) begin
            state_d   = ST_SEED;
            loss_evt  = 1'b1;
            win_sym_d = '0;
            win_err_d = '0;
          end else if (win_sym_inc == NB_WS'(LOCK_WIN)) begin
            win_sym_d = '0;
            win_err_d = '0;
          end
        end
        default: begin
          state_d   = ST_SEED;
          win_sym_d = '0;
          win_err_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_SEED;
      win_sym_q <= '0;
      win_err_q <= '0;
    end else begin
      state_q   <= state_d;
      win_sym_q <= win_sym_d;
      win_err_q <= win_err_d;
    end
  end

  logic [NB_CNT-1:0]  err_cnt_q, err_cnt_d, bit_cnt_q, bit_cnt_d;
  logic [NB_LOSS-1:0] loss_cnt_q, loss_cnt_d;
  logic [NB_CNT:0]    err_sum, bit_sum;

  assign err_sum = {1'b0, err_cnt_q} + (NB_CNT+1)'(sym_err);
  assign bit_sum = {1'b0, bit_cnt_q} + (NB_CNT+1)'(2);

  // Clear is processed after the increment so it always wins
  always_comb begin
    err_cnt_d  = err_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    loss_cnt_d = loss_cnt_q;
    if (cnt_en) begin
      err_cnt_d = err_sum[NB_CNT] ? '1 : err_sum[NB_CNT-1:0];
      bit_cnt_d = bit_sum[NB_CNT] ? '1 : bit_sum[NB_CNT-1:0];
    end
    if (loss_evt && (loss_cnt_q != LOSS_SAT)) loss_cnt_d = loss_cnt_q + NB_LOSS'(1);
    if (i_clear) begin
      err_cnt_d  = '0;
      bit_cnt_d  = '0;
      loss_cnt_d = '0;
    end
  end

  // i_en low freezes the statistics, clear included
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      err_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      loss_cnt_q <= '0;
    end else if (i_en) begin
      err_cnt_q  <= err_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign o_locked   = (state_q == ST_LOCKED);
  assign o_state    = state_q;
  assign o_err_cnt  = err_cnt_q;
  assign o_bit_cnt  = bit_cnt_q;
  assign o_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_pam4_ber_checker.sv
// Randomized and directed bench for pam4_ber_checker against a queue-based
// behavioural PRBS7/BER model, compared every cycle.
module tb_pam4_ber_checker;

  localparam int NB_IN  = 18;
  localparam int TH     = 65536;
  localparam int NB_CNT = 8;
  localparam longint CMAX = (64'd1 << NB_CNT) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    i_en = 1'b0, i_valid = 1'b0, i_clear = 1'b0;
  logic signed [NB_IN-1:0] i_sample = '0;
  logic                    o_locked;
  logic [1:0]              o_state;
  logic [NB_CNT-1:0]       o_err_cnt, o_bit_cnt;
  logic [7:0]              o_loss_cnt;

  always #5 clk = ~clk;

  pam4_ber_checker #(.NB_CNT(NB_CNT)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_en(i_en), .i_valid(i_valid),
    .i_sample(i_sample), .i_clear(i_clear), .o_locked(o_locked),
    .o_state(o_state), .o_err_cnt(o_err_cnt), .o_bit_cnt(o_bit_cnt),
    .o_loss_cnt(o_loss_cnt)
  );

  int   nchk = 0, nerr = 0;
  bit   chk_on = 0;
  logic [6:0] g = 7'h5A;
  bit   bnd_tog = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_state, m_seed_n, m_win_n, m_win_e;
  longint m_err, m_bit, m_loss;
  bit     m_pend;
  logic [1:0] m_pdec;
  int     ref_q[$];

  function automatic logic [1:0] slice(input int s);
    if (s >= TH)  return 2'b10;
    if (s >= 0)   return 2'b11;
    if (s >= -TH) return 2'b01;
    return 2'b00;
  endfunction

  task automatic m_reset();
    m_state = 0; m_seed_n = 0; m_win_n = 0; m_win_e = 0;
    m_err = 0; m_bit = 0; m_loss = 0; m_pend = 0; m_pdec = 2'b00;
    ref_q.delete();
    repeat (7) ref_q.push_back(0);
  endtask

  task automatic m_proc(input logic [1:0] d);
    int rx[2];
    int e, p;
    rx[0] = int'(d[1]); rx[1] = int'(d[0]);
    if (m_state == 0) begin
      for (int k = 0; k < 2; k++) begin
        ref_q.push_back(rx[k]);
        void'(ref_q.pop_front());
      end
      m_seed_n++;
      if (m_seed_n == 4) begin m_state = 1; m_win_n = 0; m_win_e = 0; end
    end else begin
      e = 0;
      for (int k = 0; k < 2; k++) begin
        p = ref_q[0] ^ ref_q[1];
        ref_q.push_back(p);
        void'(ref_q.pop_front());
        if (p != rx[k]) e++;
      end
      m_win_n++; m_win_e += e;
      if (m_state == 2) begin
        m_err = (m_err + e > CMAX) ? CMAX : m_err + e;
        m_bit = (m_bit + 2 > CMAX) ? CMAX : m_bit + 2;
        if (m_win_e >= 16) begin
          m_state = 0; m_seed_n = 0; m_win_n = 0; m_win_e = 0;
          m_loss = (m_loss == 255) ? 255 : m_loss + 1;
        end else if (m_win_n == 64) begin
          m_win_n = 0; m_win_e = 0;
        end
      end else if (m_win_n == 64) begin
        m_state = (m_win_e <= 2) ? 2 : 0;
        m_seed_n = 0; m_win_n = 0; m_win_e = 0;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else if (i_en) begin
        if (m_pend) m_proc(m_pdec);
        if (i_clear) begin m_err = 0; m_bit = 0; m_loss = 0; end
        m_pend = i_valid;
        m_pdec = slice(int'(i_sample));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("state",  longint'(o_state),    longint'(m_state));
      chk("locked", longint'(o_locked),   longint'(m_state == 2));
      chk("errcnt", longint'(o_err_cnt),  m_err);
      chk("bitcnt", longint'(o_bit_cnt),  m_bit);
      chk("losscnt",longint'(o_loss_cnt), m_loss);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic en, input logic vld, input logic signed [NB_IN-1:0] s,
                     input logic clr);
    @(posedge clk); #1;
    i_en = en; i_valid = vld; i_sample = s; i_clear = clr;
  endtask

  task automatic next_bits(output logic [1:0] b);
    logic b1, b0;
    b1 = g[6] ^ g[5]; g = {g[5:0], b1};
    b0 = g[6] ^ g[5]; g = {g[5:0], b0};
    b = {b1, b0};
  endtask

  function automatic logic signed [NB_IN-1:0] lvl(input logic [1:0] b, input int mode, input bit tog);
    int v;
    if (mode == 0) begin
      case (b)
        2'b10: v = 98304;  2'b11: v = 32768;
        2'b01: v = -32768; default: v = -98304;
      endcase
    end else if (mode == 1) begin
      case (b)
        2'b10: v = TH;  2'b11: v = tog ? TH - 1 : 0;
        2'b01: v = -TH; default: v = -TH - 1;
      endcase
    end else begin
      case (b)
        2'b10: v = int'($urandom_range(131071, TH));
        2'b11: v = int'($urandom_range(TH - 1, 0));
        2'b01: v = -int'($urandom_range(TH, 1));
        default: v = -int'($urandom_range(131072, TH + 1));
      endcase
    end
    return NB_IN'(v);
  endfunction

  task automatic send(input int mode, input logic [1:0] flip, input logic clr);
    logic [1:0] b;
    next_bits(b);
    bnd_tog = ~bnd_tog;
    cyc(1'b1, 1'b1, lvl(b ^ flip, mode, bnd_tog), clr);
  endtask

  task automatic flush();
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk({nm, "_rst_state"}, longint'(o_state), 0);
    chk({nm, "_rst_bit"},   longint'(o_bit_cnt), 0);
    chk({nm, "_rst_err"},   longint'(o_err_cnt), 0);
    chk({nm, "_rst_loss"},  longint'(o_loss_cnt), 0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed and random tests ----------------
  initial begin
    #1 chk_on = 1;
    repeat (3) cyc(1'b1, 1'b0, '0, 1'b0);
    chk("init_state", longint'(o_state), 0);
    chk("init_bit",   longint'(o_bit_cnt), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // clean PRBS7 at nominal levels
    repeat (67) send(0, 2'b00, 1'b0);
    flush();
    chk("t1_lock67", longint'(o_locked), 0);
    chk("t1_qual67", longint'(o_state), 1);
    send(0, 2'b00, 1'b0);
    flush();
    chk("t1_lock68", longint'(o_locked), 1);
    repeat (32) send(0, 2'b00, 1'b0);
    flush();
    chk("t1_err100", longint'(o_err_cnt), 0);
    chk("t1_bit100", longint'(o_bit_cnt), 64);

    // lock with boundary samples, then one flip per 4 symbols
    do_reset("t2");
    repeat (68) send(1, 2'b00, 1'b0);
    flush();
    chk("t2_bnd_lock", longint'(o_locked), 1);
    for (int i = 0; i < 64; i++) send(0, (i % 4 == 0) ? 2'b10 : 2'b00, 1'b0);
    flush();
    chk("t2_state", longint'(o_state), 0);
    chk("t2_loss",  longint'(o_loss_cnt), 1);
    chk("t2_err",   longint'(o_err_cnt), 16);
    chk("t2_bit",   longint'(o_bit_cnt), 122);

    // reset mid-QUAL, then relock
    do_reset("t3a");
    repeat (30) send(0, 2'b00, 1'b0);
    flush();
    chk("t3_inqual", longint'(o_state), 1);
    do_reset("t3b");
    repeat (67) send(0, 2'b00, 1'b0);
    flush();
    chk("t3_nolock67", longint'(o_locked), 0);
    send(0, 2'b00, 1'b0);
    flush();
    chk("t3_relock", longint'(o_locked), 1);

    // gapped valid and enable-low bursts
    do_reset("t4");
    for (int k = 0; k < 100; k++) begin
      cyc(1'b1, 1'b0, NB_IN'(12345), 1'b0);
      if (k % 10 == 3) repeat (3) cyc(1'b0, 1'b1, NB_IN'(-777), 1'b1);
      send(0, 2'b00, 1'b0);
    end
    flush();
    chk("t4_lock", longint'(o_locked), 1);
    chk("t4_err",  longint'(o_err_cnt), 0);
    chk("t4_bit",  longint'(o_bit_cnt), 64);

    // saturation, then clear racing an error
    for (int i = 0; i < 3000; i++) send(0, (i % 6 == 0) ? 2'b01 : 2'b00, 1'b0);
    flush();
    chk("t5_satbit", longint'(o_bit_cnt), 255);
    chk("t5_saterr", longint'(o_err_cnt), 255);
    chk("t5_locked", longint'(o_locked), 1);
    send(0, 2'b10, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("t5_clr_err", longint'(o_err_cnt), 0);
    chk("t5_clr_bit", longint'(o_bit_cnt), 0);
    chk("t5_clr_st",  longint'(o_state), 2);

    // random traffic with varying error rates
    for (int seg = 0; seg < 15; seg++) begin
      int rate;
      case ($urandom_range(0, 2))
        0: rate = 0;
        1: rate = 20;
        default: rate = 3;
      endcase
      for (int c = 0; c < 200; c++) begin
        int r;
        logic clr;
        logic [1:0] fl;
        r   = int'($urandom_range(0, 99));
        clr = ($urandom_range(0, 59) == 0);
        if (r < 8)
          cyc(1'b0, 1'($urandom_range(0, 1)), lvl(2'($urandom_range(0, 3)), 2, 1'b0), clr);
        else if (r < 45)
          cyc(1'b1, 1'b0, lvl(2'($urandom_range(0, 3)), 2, 1'b0), clr);
        else begin
          fl = 2'b00;
          if (rate != 0 && $urandom_range(0, rate - 1) == 0)
            fl = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
          send(2, fl, clr);
        end
      end
    end
    flush();
    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
